// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// A fractional accumulator produces ticks at oversample x baud. The line is
// brought into the clk domain through a two-flop synchronizer. An FSM then
// samples the start, data and stop bits at their midpoints. Each good byte
// is presented with a one-cycle data_ready strobe. A stop bit that samples
// low raises frame_error and parks the FSM until the line returns high.
module uart_rx #(
    parameter int clkFrequency = 50000000,
    parameter int baud         = 115200,
    parameter int oversample   = 8,
    parameter int accWidth     = 16,
    parameter int accInc       = int'(((64'(baud) * 64'(oversample)) << accWidth)
                                      / 64'(clkFrequency))
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_ready,
    output logic       frame_error,
    output logic       busy
);

    // Accumulator carries one extra bit; that bit is the tick.
    localparam int ACC_W = accWidth + 1;
    localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(accInc);

    // Tick counter spans one bit period (oversample is a power of two).
    localparam int CNT_W = $clog2(oversample);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(oversample / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(oversample - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    // Synchronizer stages. Both reset high, so reset never looks like a start bit.
    logic rxd_meta_q;
    logic rxs_q;

    // Tick generator.
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             tick;

    // Receiver state.
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic [7:0]       data_q;
    logic [7:0]       data_d;
    logic             data_ready_q;
    logic             data_ready_d;
    logic             frame_error_q;
    logic             frame_error_d;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxs_q      <= rxd_meta_q;
        end
    end

    // Drop last cycle's overflow bit and add the increment. The carry out is the next tick.
    always_comb begin
        acc_d = {1'b0, acc_q[accWidth-1:0]} + ACC_INC;
    end

    assign tick = acc_q[accWidth];

    // Free-running accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Receive FSM: it moves only on ticks. The strobe defaults low, so it lasts one clk.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_ready_d  = 1'b0;
        frame_error_d = frame_error_q;

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs_q) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end

                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        // Mid start bit: a high line means it was only a glitch.
                        if (rxs_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                            idx_d   = 3'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_DATA: begin
                    // cnt wraps to zero at each data-bit midpoint.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        shift_d = {rxs_q, shift_q[7:1]};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        if (rxs_q) begin
                            // Go back to IDLE at mid stop. A start bit that follows
                            // right away still has half a bit of margin.
                            data_d        = shift_q;
                            data_ready_d  = 1'b1;
                            frame_error_d = 1'b0;
                            state_d       = ST_IDLE;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = ST_WAIT_IDLE;
                        end
                    end
                end

                ST_WAIT_IDLE: begin
                    // A held-low line (break) must not decode as a run of 0x00 frames.
                    if (rxs_q) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Receiver state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            shift_q       <= 8'h00;
            data_q        <= 8'h00;
            data_ready_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_ready_q  <= data_ready_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign data        = data_q;
    assign data_ready  = data_ready_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at the default parameters.
// Frames are bit-banged onto rxd at a given number of clk per bit.
// A monitor records every data_ready strobe, so strobe counts, byte order
// and latency can be checked after each step.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] data;
    logic       data_ready;
    logic       frame_error;
    logic       busy;

    int total;
    int bad;

    // Updated only by the monitor processes.
    int         cyc;
    int         strobes;
    int         strobe_cyc;
    logic [7:0] caught [0:255];

    uart_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .data        (data),
        .data_ready  (data_ready),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter, used for latency measurement.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample the strobe away from the active edge. A strobe that lasts two
    // cycles is counted twice.
    initial strobes = 0;
    always @(negedge clk) begin
        if (data_ready === 1'b1) begin
            caught[strobes[7:0]] = data;
            strobe_cyc = cyc;
            strobes = strobes + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base;
    int start_cyc;
    int lat;
    logic [7:0] saved;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        rxd   = 1'b1;

        // Hold reset while rxd toggles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rxd = ~rxd;
        end
        check("rst_data", int'(data), 'h00);
        check("rst_ready", int'(data_ready), 0);
        check("rst_ferr", int'(frame_error), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_strobes", strobes, 0);
        rxd = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(100);

        // Single frame 0x55 at nominal rate, with the latency window.
        base = strobes;
        @(negedge clk);
        start_cyc = cyc;
        send_frame(8'h55, 434, 1'b1);
        idle(200);
        lat = strobe_cyc - start_cyc;
        check("s55_count", strobes - base, 1);
        check("s55_data", int'(data), 'h55);
        check("s55_lat_ok", int'(lat >= 4123 && lat <= 4190), 1);
        check("s55_busy", int'(busy), 0);
        check("s55_ferr", int'(frame_error), 0);

        // Pulse reset for one clk in the middle of a frame.
        base = strobes;
        rxd = 1'b0;
        idle(434 * 3);
        check("mid_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", int'(data), 'h00);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(data_ready), 0);
        check("mid_rst_ferr", int'(frame_error), 0);
        rxd = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1000);
        check("mid_no_strobe", strobes - base, 0);
        send_frame(8'h5A, 434, 1'b1);
        idle(200);
        check("s5A_count", strobes - base, 1);
        check("s5A_data", int'(data), 'h5A);

        // Back-to-back frames with no idle gap.
        base = strobes;
        send_frame(8'hA3, 434, 1'b1);
        send_frame(8'h00, 434, 1'b1);
        send_frame(8'hFF, 434, 1'b1);
        idle(300);
        check("b2b_count", strobes - base, 3);
        check("b2b_byte0", int'(caught[base[7:0]]), 'hA3);
        check("b2b_byte1", int'(caught[8'(base + 1)]), 'h00);
        check("b2b_byte2", int'(caught[8'(base + 2)]), 'hFF);
        check("b2b_ferr", int'(frame_error), 0);

        // A 100 clk low glitch is rejected as a false start.
        base  = strobes;
        saved = data;
        rxd = 1'b0;
        idle(100);
        rxd = 1'b1;
        idle(300);
        check("glitch_busy", int'(busy), 0);
        check("glitch_strobe", strobes - base, 0);
        check("glitch_data", int'(data), int'(saved));

        // Framing error: a good 0x12, then 0x3C with a low stop bit and a break.
        base = strobes;
        send_frame(8'h12, 434, 1'b1);
        idle(200);
        check("s12_data", int'(data), 'h12);
        check("s12_ferr", int'(frame_error), 0);
        send_frame(8'h3C, 434, 1'b0);
        idle(434 * 2);
        rxd = 1'b1;
        idle(500);
        check("fe_flag", int'(frame_error), 1);
        check("fe_count", strobes - base, 1);
        check("fe_data", int'(data), 'h12);
        check("fe_busy", int'(busy), 0);
        send_frame(8'h81, 434, 1'b1);
        idle(200);
        check("s81_count", strobes - base, 2);
        check("s81_data", int'(data), 'h81);
        check("s81_ferr", int'(frame_error), 0);

        // Sender rate tolerance, slow and fast.
        base = strobes;
        send_frame(8'hC9, 425, 1'b1);
        idle(200);
        check("fast_count", strobes - base, 1);
        check("fast_data", int'(data), 'hC9);
        check("fast_ferr", int'(frame_error), 0);
        send_frame(8'hC9, 443, 1'b1);
        idle(200);
        check("slow_count", strobes - base, 2);
        check("slow_data", int'(data), 'hC9);
        check("slow_ferr", int'(frame_error), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- RS232 receiver: the receive-side counterpart of the existing transmit baud path.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous rxd line.
- Uses an internal fractional-accumulator tick generator running at OVERSAMPLE x baud, and samples each bit at its midpoint.
- Delivers each byte with a one-cycle strobe to the processor-side I/O logic; flags framing errors.

Parameters:
- clkFrequency, 50000000: system clock frequency in Hz.
- baud, 115200: line bit rate.
- oversample, 8: ticks per bit period; must be a power of 2, minimum 4.
- accWidth, 16: fractional accumulator width.
- accInc, ((baud*oversample)<<accWidth)/clkFrequency: accumulator increment, truncating; 1207 at defaults.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- data  output  8  last correctly received byte.
- data_ready  output  1  one-cycle strobe; data is valid in the same cycle and held afterwards.
- frame_error  output  1  high after a frame whose stop bit sampled 0; cleared by the next good frame.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - data=0x00, data_ready=0, frame_error=0, busy=0.
  - Synchronizer flops=1, accumulator=0, tick counter=0, state=IDLE.
  - Reset mid-frame discards the partial frame; no strobe is produced.
- rxd passes through a 2-flop synchronizer. All decisions use the synchronized value rxs (2-cycle latency).
- Tick generator:
  - (accWidth+1)-bit accumulator; each clk: acc <= acc[accWidth-1:0] + accInc.
  - tick = acc[accWidth], registered; free-running, never stalled.
  - Defaults: one tick about every 54.3 clk; 8 ticks about 434 clk = 1 bit.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. A 3-bit tick counter cnt and a 3-bit bit index idx are used.
- Outside the single tick cycle, state, cnt and idx hold.
- IDLE: on a tick with rxs=0 -> START, cnt=0.
- START:
  - On each tick cnt++.
  - When cnt reaches oversample/2-1 (mid start bit), check rxs:
    - rxs=1 -> false start, return to IDLE, no outputs change.
    - rxs=0 -> DATA, cnt=0, idx=0.
- DATA:
  - On each tick cnt++.
  - When cnt wraps from oversample-1 to 0 (bit midpoint), shift rxs into shift[7] (right shift, so LSB lands first) and idx++.
  - After the 8th data sample -> STOP.
- STOP: at the midpoint tick of the stop bit, rxs is sampled.
  - rxs=1 -> data<=shift; data_ready=1 for exactly the next clk; frame_error<=0; -> IDLE.
  - rxs=0 -> frame_error<=1; data unchanged; no strobe; -> WAIT_IDLE.
- WAIT_IDLE: on a tick with rxs=1 -> IDLE. This prevents a break condition from being decoded as 0x00 frames.
- Latency: data_ready asserts one clk after the stop-bit midpoint tick, about 9.5 bit periods plus up to 1 tick plus 3 clk after the rxd falling edge.
- Back-to-back frames: a start bit immediately following the stop bit must be accepted. IDLE is re-entered at mid-stop, leaving half a bit of margin.
- busy=1 in START, DATA, STOP, WAIT_IDLE; 0 in IDLE.
- Baud error tolerance: a sender within ±2% of baud must decode correctly.

Test Plan:
- Reset: hold rst_n=0 with rxd toggling -> data=0x00, data_ready=0, frame_error=0, busy=0. Pulse rst_n low for 1 clk mid-frame -> immediate return to these values; a subsequent frame 0x5A decodes correctly.
- Single frame 0x55 at 434 clk/bit -> exactly one 1-cycle data_ready, data=0x55, strobe between 4123 and 4190 clk after the start edge, busy=0 afterwards.
- Back-to-back 0xA3, 0x00, 0xFF with no idle gap -> three strobes, data sequence 0xA3, 0x00, 0xFF, frame_error stays 0.
- Glitch: rxd low for 100 clk then high -> no data_ready, busy returns to 0 within 5 ticks, data unchanged.
- Framing error: after a good 0x12, send 0x3C with stop bit 0, then hold the line low 2 bit periods, then high -> frame_error=1, no strobe, data=0x12, no extra frames. A following 0x81 produces a strobe, data=0x81, frame_error=0.
- Rate tolerance: frames 0xC9 sent at 425 and 443 clk/bit -> both decoded correctly.
